// File: rtl/cam_emu_pkg.sv
// cam_emu_pkg: state encodings and FIFO entry layout shared by
// the DVP camera emulator (optional line check: CAM_EMU_LINECHK_EN).
package cam_emu_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_VSYNC  = 3'd1;
   localparam state_t ST_VBP    = 3'd2;
   localparam state_t ST_LINE   = 3'd3;
   localparam state_t ST_HBLANK = 3'd4;

   typedef struct packed {
      logic        sof;
      logic        eol;
      logic [15:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/cam_emu_fifo.sv
// cam_emu_fifo: synchronous show-ahead FIFO; rdata is the head entry
// whenever empty is low. Pushes when full and pops when empty are ignored.
module cam_emu_fifo #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 18
) (
   input  logic             i_sysclk,
   input  logic             i_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge i_sysclk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= nxt(wr_ptr);
         if (do_pop)
            rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/cam_emulate_saxis.sv
// cam_emulate_saxis: AXIS video slave regenerating OV7670-style DVP timing.
// Define CAM_EMU_LINECHK_EN to enable the sticky line-length check.
module cam_emulate_saxis
   import cam_emu_pkg::*;
#(
   parameter int X_RES        = 640,
   parameter int PCLK_DIV     = 4,
   parameter int VSYNC_PCLKS  = 2 * X_RES,
   parameter int VBP_PCLKS    = 8,
   parameter int HBLANK_PCLKS = 2
) (
   input  logic        i_sysclk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic [15:0] S_AXIS_VIDEO_TDATA,
   input  logic        S_AXIS_VIDEO_TVALID,
   output logic        S_AXIS_VIDEO_TREADY,
   input  logic        S_AXIS_VIDEO_TUSER,
   input  logic        S_AXIS_VIDEO_TLAST,
   output logic        o_pclk,
   output logic        o_vsync,
   output logic        o_href,
   output logic [7:0]  o_data,
   output logic        o_line_err
);

   localparam int DEPTH = 2 * X_RES;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int HALF  = PCLK_DIV / 2;
   localparam int DW    = $clog2(PCLK_DIV);
   localparam int TW    = $clog2(VSYNC_PCLKS + VBP_PCLKS + HBLANK_PCLKS + 1);

   fifo_entry_t   wr_entry;
   fifo_entry_t   head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          accept;
   logic          acc_last;
   logic          rst_done;
   logic [LW-1:0] lines_avail;
   logic [DW-1:0] div_cnt;
   logic [TW-1:0] tcnt;
   state_t        state;
   logic          phase;
   logic          line_end;
   logic          pclk_run;
   logic          fall_tick;
   logic          go;
   logic          decide;
   logic          line_start;

   assign S_AXIS_VIDEO_TREADY = rst_done & i_enable & ~fifo_full;
   assign accept   = S_AXIS_VIDEO_TVALID & S_AXIS_VIDEO_TREADY;
   assign acc_last = accept & S_AXIS_VIDEO_TLAST;

   assign wr_entry.sof  = S_AXIS_VIDEO_TUSER;
   assign wr_entry.eol  = S_AXIS_VIDEO_TLAST;
   assign wr_entry.data = S_AXIS_VIDEO_TDATA;

   cam_emu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .i_sysclk (i_sysclk),
      .i_reset  (i_reset),
      .push     (accept),
      .wdata    (wr_entry),
      .pop      (fifo_pop),
      .rdata    (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // pclk only stops when parked in IDLE with the enable low
   assign pclk_run  = !(state == ST_IDLE && !i_enable);
   assign fall_tick = pclk_run && o_pclk && (div_cnt == DW'(HALF - 1));
   assign go        = i_enable && (lines_avail != '0) && !fifo_empty;
   assign decide    = fall_tick &&
                      (state == ST_IDLE ||
                       (state == ST_HBLANK && tcnt == TW'(HBLANK_PCLKS - 1)));
   assign line_start = (decide && go && !head.sof) ||
                       (fall_tick && state == ST_VBP &&
                        tcnt == TW'(VBP_PCLKS - 1));
   assign fifo_pop  = fall_tick && state == ST_LINE && phase;

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset)
         rst_done <= 1'b0;
      else
         rst_done <= 1'b1;
   end

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         div_cnt <= '0;
         o_pclk  <= 1'b0;
      end else if (!pclk_run) begin
         div_cnt <= '0;
         o_pclk  <= 1'b0;
      end else if (div_cnt == DW'(HALF - 1)) begin
         div_cnt <= '0;
         o_pclk  <= ~o_pclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset)
         lines_avail <= '0;
      else if (acc_last && !line_start)
         lines_avail <= lines_avail + 1'b1;
      else if (line_start && !acc_last)
         lines_avail <= lines_avail - 1'b1;
   end

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         tcnt     <= '0;
         phase    <= 1'b0;
         line_end <= 1'b0;
         o_vsync  <= 1'b0;
         o_href   <= 1'b0;
         o_data   <= '0;
      end else if (fall_tick) begin
         if (decide) begin
            tcnt <= '0;
            if (!go) begin
               state <= ST_IDLE;
            end else if (head.sof) begin
               state   <= ST_VSYNC;
               o_vsync <= 1'b1;
            end else begin
               state  <= ST_LINE;
               o_href <= 1'b1;
               o_data <= head.data[7:0];
               phase  <= 1'b1;
            end
         end else begin
            case (state)
               ST_VSYNC:
                  if (tcnt == TW'(VSYNC_PCLKS - 1)) begin
                     state   <= ST_VBP;
                     o_vsync <= 1'b0;
                     tcnt    <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               ST_VBP:
                  if (tcnt == TW'(VBP_PCLKS - 1)) begin
                     state  <= ST_LINE;
                     o_href <= 1'b1;
                     o_data <= head.data[7:0];
                     phase  <= 1'b1;
                     tcnt   <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               ST_LINE:
                  if (phase) begin
                     o_data   <= head.data[15:8];
                     phase    <= 1'b0;
                     line_end <= head.eol;
                  end else if (line_end) begin
                     state    <= ST_HBLANK;
                     o_href   <= 1'b0;
                     o_data   <= '0;
                     line_end <= 1'b0;
                     tcnt     <= '0;
                  end else begin
                     o_data <= head.data[7:0];
                     phase  <= 1'b1;
                  end
               ST_HBLANK:
                  tcnt <= tcnt + 1'b1;
               default:
                  state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef CAM_EMU_LINECHK_EN
   logic [15:0] pix_cnt;

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         pix_cnt    <= '0;
         o_line_err <= 1'b0;
      end else if (fifo_pop) begin
         if (head.eol) begin
            pix_cnt <= '0;
            if (pix_cnt + 16'd1 != 16'(X_RES))
               o_line_err <= 1'b1;
         end else begin
            pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end
`else
   assign o_line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_emulate_saxis.sv
// tb_cam_emulate_saxis: scoreboard bench for the DVP camera emulator;
// expected pixels, href widths and vsync widths are queued at AXIS acceptance.
module tb_cam_emulate_saxis;

   localparam int X_RES        = 64;
   localparam int PCLK_DIV     = 4;
   localparam int VSYNC_PCLKS  = 128;
   localparam int VBP_PCLKS    = 8;
   localparam int HBLANK_PCLKS = 2;
   localparam int BUDGET       = 20000;

   logic        i_sysclk = 1'b0;
   logic        i_reset  = 1'b1;
   logic        i_enable = 1'b1;
   logic [15:0] tdata    = '0;
   logic        tvalid   = 1'b0;
   logic        tready;
   logic        tuser    = 1'b0;
   logic        tlast    = 1'b0;
   logic        o_pclk;
   logic        o_vsync;
   logic        o_href;
   logic [7:0]  o_data;
   logic        o_line_err;

   int checks = 0;
   int errors = 0;

   logic [15:0] pix_q [$];
   int          line_q [$];
   int          vs_q [$];

   int linelen = 0;
   int acc_cnt = 0;
   logic burst_track = 1'b0;
   logic drop_seen = 1'b0;
   int drop_at = -1;

   cam_emulate_saxis #(
      .X_RES        (X_RES),
      .PCLK_DIV     (PCLK_DIV),
      .VSYNC_PCLKS  (VSYNC_PCLKS),
      .VBP_PCLKS    (VBP_PCLKS),
      .HBLANK_PCLKS (HBLANK_PCLKS)
   ) dut (
      .i_sysclk            (i_sysclk),
      .i_reset             (i_reset),
      .i_enable            (i_enable),
      .S_AXIS_VIDEO_TDATA  (tdata),
      .S_AXIS_VIDEO_TVALID (tvalid),
      .S_AXIS_VIDEO_TREADY (tready),
      .S_AXIS_VIDEO_TUSER  (tuser),
      .S_AXIS_VIDEO_TLAST  (tlast),
      .o_pclk              (o_pclk),
      .o_vsync             (o_vsync),
      .o_href              (o_href),
      .o_data              (o_data),
      .o_line_err          (o_line_err)
   );

   always #5 i_sysclk = ~i_sysclk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pat(input int ln, input int i);
      return {8'(i * 3 + ln * 5 + 1), 8'(i ^ (ln << 5))};
   endfunction

   // monitor: samples DVP outputs on observed pclk rises
   logic       prev_pclk = 1'b0;
   logic       in_line   = 1'b0;
   logic       vs_on     = 1'b0;
   logic       vbp_on    = 1'b0;
   logic       gap_ok    = 1'b0;
   int         hcnt      = 0;
   int         vs_cnt    = 0;
   int         vbp_cnt   = 0;
   int         gap       = 0;
   logic [7:0] lo        = '0;

   always @(negedge i_sysclk) begin
      if (i_reset) begin
         prev_pclk = 1'b0;
         in_line   = 1'b0;
         vs_on     = 1'b0;
         vbp_on    = 1'b0;
         gap_ok    = 1'b0;
         hcnt      = 0;
         vs_cnt    = 0;
      end else begin
         if (o_pclk && !prev_pclk) begin
            if (o_vsync) begin
               vs_on  = 1'b1;
               vs_cnt++;
               gap_ok = 1'b0;
            end else if (vs_on) begin
               vs_on = 1'b0;
               if (vs_q.size() == 0)
                  chk("vsync_expected", 0, 1);
               else
                  chk("vsync_width", vs_cnt, vs_q.pop_front());
               vs_cnt  = 0;
               vbp_on  = 1'b1;
               vbp_cnt = 0;
            end
            if (vbp_on && !o_vsync && !o_href)
               vbp_cnt++;
            if (o_href) begin
               if (!in_line) begin
                  in_line = 1'b1;
                  hcnt    = 0;
                  if (vbp_on) begin
                     chk("vbp_width", vbp_cnt, VBP_PCLKS);
                     vbp_on = 1'b0;
                  end
                  if (gap_ok)
                     chk("hblank_min", int'(gap >= HBLANK_PCLKS), 1);
               end
               hcnt++;
               if (hcnt % 2 == 1) begin
                  lo = o_data;
               end else if (pix_q.size() == 0) begin
                  chk("pixel_expected", 0, 1);
               end else begin
                  chk("pixel", int'({o_data, lo}), int'(pix_q.pop_front()));
               end
            end else if (in_line) begin
               in_line = 1'b0;
               gap     = 1;
               gap_ok  = 1'b1;
               if (line_q.size() == 0)
                  chk("line_expected", 0, 1);
               else
                  chk("href_width", hcnt, line_q.pop_front());
            end else begin
               gap++;
            end
         end
         prev_pclk = o_pclk;
      end
   end

   // called just after a negedge; returns just after a negedge
   task automatic send_pix(input logic [15:0] d, input logic sof,
                           input logic eol);
      int t = 0;
      tdata  = d;
      tuser  = sof;
      tlast  = eol;
      tvalid = 1'b1;
      while (!tready && t < BUDGET) begin
         if (burst_track && !drop_seen) begin
            drop_seen = 1'b1;
            drop_at   = acc_cnt;
         end
         @(negedge i_sysclk);
         t++;
      end
      if (!tready) begin
         chk("tready_wait", int'(tready), 1);
      end else begin
         @(posedge i_sysclk);
         acc_cnt++;
         pix_q.push_back(d);
         if (sof)
            vs_q.push_back(VSYNC_PCLKS);
         linelen++;
         if (eol) begin
            line_q.push_back(2 * linelen);
            linelen = 0;
         end
         @(negedge i_sysclk);
      end
      tvalid = 1'b0;
      tuser  = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic send_line(input int ln, input int n, input logic sof);
      for (int i = 0; i < n; i++)
         send_pix(pat(ln, i), sof && (i == 0), i == n - 1);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((pix_q.size() != 0 || line_q.size() != 0 ||
              vs_q.size() != 0 || in_line) && t < BUDGET) begin
         @(negedge i_sysclk);
         t++;
      end
      chk(name, pix_q.size() + line_q.size() + vs_q.size(), 0);
   endtask

   initial begin
      int n;
      repeat (5) @(negedge i_sysclk);
      chk("rst_pclk", int'(o_pclk), 0);
      chk("rst_vsync", int'(o_vsync), 0);
      chk("rst_href", int'(o_href), 0);
      chk("rst_data", int'(o_data), 0);
      chk("rst_line_err", int'(o_line_err), 0);
      chk("rst_tready", int'(tready), 0);
      i_reset = 1'b0;
      #1;
      chk("tready_at_release", int'(tready), 0);
      @(negedge i_sysclk);
      chk("tready_after_release", int'(tready), 1);

      // three-line frame
      send_line(0, 64, 1'b1);
      send_line(1, 64, 1'b0);
      send_line(2, 64, 1'b0);
      drain("frame3_drain");
      chk("line_err_frame3", int'(o_line_err), 0);

      // back-to-back burst fills the FIFO during vsync
      acc_cnt     = 0;
      drop_seen   = 1'b0;
      burst_track = 1'b1;
      send_line(3, 64, 1'b1);
      send_line(4, 64, 1'b0);
      send_line(5, 64, 1'b0);
      burst_track = 1'b0;
      chk("tready_dropped", int'(drop_seen), 1);
      chk("tready_drop_at", drop_at, 2 * X_RES);
      drain("burst_drain");

      // late second line: no extra vsync, bounded latency
      send_line(6, 64, 1'b1);
      drain("late_l1_drain");
      repeat (500) @(negedge i_sysclk);
      chk("late_href_low", int'(o_href), 0);
      chk("late_vsync_low", int'(o_vsync), 0);
      send_line(7, 64, 1'b0);
      n = 0;
      while (!o_href && n < 50) begin
         @(negedge i_sysclk);
         n++;
      end
      chk("tlast_to_href_ok", int'(n <= PCLK_DIV + 1), 1);
      drain("late_l2_drain");
      chk("line_err_clean", int'(o_line_err), 0);

      // short line
      send_line(8, 63, 1'b0);
      drain("short_drain");
`ifdef CAM_EMU_LINECHK_EN
      chk("line_err_short", int'(o_line_err), 1);
`else
      chk("line_err_short", int'(o_line_err), 0);
`endif

      // reset in the middle of a line
      send_line(9, 64, 1'b1);
      send_line(10, 64, 1'b0);
      n = 0;
      while (!(in_line && hcnt >= 40) && n < BUDGET) begin
         @(negedge i_sysclk);
         n++;
      end
      chk("reached_pixel20", int'(in_line && hcnt >= 40), 1);
      i_reset = 1'b1;
      #1;
      chk("midrst_pclk", int'(o_pclk), 0);
      chk("midrst_href", int'(o_href), 0);
      chk("midrst_vsync", int'(o_vsync), 0);
      chk("midrst_data", int'(o_data), 0);
      chk("midrst_line_err", int'(o_line_err), 0);
      chk("midrst_tready", int'(tready), 0);
      pix_q.delete();
      line_q.delete();
      vs_q.delete();
      linelen = 0;
      repeat (3) @(negedge i_sysclk);
      i_reset = 1'b0;
      @(negedge i_sysclk);
      send_line(11, 64, 1'b1);
      drain("post_reset_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
